commit_stage: RTL and testbench
===============================

// Module: commit_stage
// PURPOSE
//   Retirement/commit stage downstream of wb_stage. Registers each retired instruction
//   into difftest-ready commit signals. Detects the trap instruction and halts the core
//   view. Keeps cycle/instruction counters. Runs a no-retire watchdog.
//   Drives DifftestInstrCommit and DifftestTrapEvent from the top level.
// PARAMETERS
//   PC_START      64'h8000_0000  reset PC; a retire with pc==PC_START && inst==0 is a bubble, ignored
//   TRAP_OPCODE   7'h6b          inst[6:0] value that ends simulation (good/bad trap)
//   WDOG_CYCLES   32'd65536      consecutive RUN cycles without retire before timeout trap; 0 disables
//   WDOG_CODE     8'hff          trap_code reported on watchdog timeout
// PORTS
//   clk             in   1   core clock
//   rst             in   1   synchronous reset, active high
//   retire          in   1   one-cycle strobe: instruction completed write-back this cycle
//   pc              in   64  PC of retiring instruction
//   inst            in   32  retiring instruction word
//   rd_wen          in   1   GPR write enable from wb_stage
//   rd              in   5   destination register
//   rd_wdata        in   64  write-back data
//   skip            in   1   instruction must be skipped by difftest (MMIO etc.)
//   a0              in   64  current x10 value (trap code / putch char)
//   cmt_valid       out  1   registered commit strobe
//   cmt_pc          out  64  committed PC
//   cmt_inst        out  32  committed instruction
//   cmt_skip        out  1   committed skip flag
//   cmt_wen         out  1   committed GPR write (forced 0 when rd==0)
//   cmt_wdest       out  8   {3'b0, rd}
//   cmt_wdata       out  64  committed write data
//   trap_valid      out  1   high from the cycle after trap until reset
//   trap_code       out  8   a0[7:0] at trap, or WDOG_CODE
//   cycle_cnt       out  64  cycles spent in RUN
//   instr_cnt       out  64  accepted retires
//   uart_out_valid  out  1   (COMMIT_PUTCH_EN only) one-cycle char strobe
//   uart_out_ch     out  8   (COMMIT_PUTCH_EN only) character
// BEHAVIOUR
//   Reset: every output 0, state=RUN, watchdog count 0.
//   Accepted retire (acc) = retire && state==RUN && !(pc==PC_START && inst==0).
//   Latency 1: acc in cycle N -> cmt_valid=1 with pc/inst/skip/wen/wdest/wdata in N+1.
//   cmt_valid low on any cycle without acc; other cmt_* hold last value.
//   States: RUN -> HALT on (acc && inst[6:0]==TRAP_OPCODE): trap_code<=a0[7:0].
//     RUN -> HALT on watchdog expiry: trap_code<=WDOG_CODE, cmt_valid stays 0.
//     HALT is absorbing: no commits, counters frozen, trap_valid=1; only rst leaves.
//   Trap instruction itself commits (cmt_valid=1, instr_cnt counts it) in the same cycle trap_valid rises.
//   cycle_cnt +1 every RUN cycle, including the trap cycle. instr_cnt +1 per acc.
//     Both wrap modulo 2^64.
//   Watchdog: count cleared on acc, +1 otherwise in RUN. Expiry when count==WDOG_CYCLES-1 and no acc.
//     Same-cycle acc and expiry -> acc wins, no timeout.
//   rst mid-run or in HALT: immediate return to reset values next cycle.
// CONFIGURATION
//   COMMIT_PUTCH_EN defined: acc && inst==32'h7 -> uart_out_valid=1, uart_out_ch=a0[7:0] next cycle.
//     The putch instruction also commits normally.
//   Not defined: uart_out_valid/uart_out_ch tied 0; no putch logic.
// STRUCTURE
//   Shared defines (defines.v): PC_START, TRAP_OPCODE, putch encoding 32'h7, 1-bit state encoding RUN/HALT.
//   One sub-module: commit_watchdog (count/clear/expire, WDOG_CYCLES parameter, 0 = never expires).
// TESTING
//   Retire pc=0x80000000 inst=0x00100093 rd=1 wdata=1 -> next cycle cmt_valid=1, cmt_wdest=1, cmt_wen=1, instr_cnt=1.
//   Retire pc=0x80000000 inst=0 -> cmt_valid=0, instr_cnt unchanged; rd_wen=1 rd=0 retire -> cmt_wen=0.
//   Retire inst=0x0000006b, a0=0 -> trap_valid=1, trap_code=0x00. Further retires give no cmt_valid; counters frozen.
//   WDOG_CYCLES=16, no retire -> trap_valid=1 at cycle 17 after reset, code 0xff.
//     Retire on the 16th cycle -> no trap.
//   COMMIT_PUTCH_EN, inst=0x7, a0=0x41 -> uart_out_valid pulse with ch=0x41.
//     Without the macro, uart_out_valid stays 0.
//   Assert rst while in HALT -> next cycle trap_valid=0, counters 0, commits resume.

Source files
------------

// File: rtl/commit_stage_pkg.sv
// Shared constants and state encoding for the commit stage and its watchdog.
package commit_stage_pkg;

  localparam logic [63:0] PC_START    = 64'h8000_0000;
  localparam logic [6:0]  TRAP_OPCODE = 7'h6b;
  localparam logic [31:0] PUTCH_INST  = 32'h0000_0007;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_e;

  // The pipeline presents pc==PC_START with a zero word while it is still filling.
  function automatic logic is_bubble(input logic [63:0] pc, input logic [31:0] inst);
    return (pc == PC_START) && (inst == 32'h0);
  endfunction

endpackage

// File: rtl/commit_stage_watchdog.sv
// No-retire watchdog: counts RUN cycles without a retire; WDOG_CYCLES==0 never expires.
module commit_watchdog #(
  parameter logic [31:0] WDOG_CYCLES = 32'd65536
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  input  logic clear_i,
  output logic expire_o
);

  logic [31:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (run_i) begin
      count_d = clear_i ? 32'd0 : count_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) count_q <= 32'd0;
    else       count_q <= count_d;
  end

  // A retire in the expiry cycle clears the count and suppresses the timeout.
  assign expire_o = (WDOG_CYCLES != 32'd0) && run_i && !clear_i &&
                    (count_q == WDOG_CYCLES - 32'd1);

endmodule

// File: rtl/commit_stage.sv
// Commit/retire stage: registers retired instructions for difftest, detects trap and
// watchdog halt, keeps cycle/instruction counters. Optional putch output: COMMIT_PUTCH_EN.
module commit_stage
  import commit_stage_pkg::*;
#(
  parameter logic [31:0] WDOG_CYCLES = 32'd65536,
  parameter logic [7:0]  WDOG_CODE   = 8'hff
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        retire_i,
  input  logic [63:0] pc_i,
  input  logic [31:0] inst_i,
  input  logic        rd_wen_i,
  input  logic [4:0]  rd_i,
  input  logic [63:0] rd_wdata_i,
  input  logic        skip_i,
  input  logic [63:0] a0_i,
  output logic        cmt_valid_o,
  output logic [63:0] cmt_pc_o,
  output logic [31:0] cmt_inst_o,
  output logic        cmt_skip_o,
  output logic        cmt_wen_o,
  output logic [7:0]  cmt_wdest_o,
  output logic [63:0] cmt_wdata_o,
  output logic        trap_valid_o,
  output logic [7:0]  trap_code_o,
  output logic [63:0] cycle_cnt_o,
  output logic [63:0] instr_cnt_o,
  output logic        uart_out_valid_o,
  output logic [7:0]  uart_out_ch_o
);

  state_e      state_q, state_d;
  logic [7:0]  trap_code_q, trap_code_d;
  logic        cmt_valid_q;
  logic [63:0] cmt_pc_q;
  logic [31:0] cmt_inst_q;
  logic        cmt_skip_q;
  logic        cmt_wen_q;
  logic [4:0]  cmt_rd_q;
  logic [63:0] cmt_wdata_q;
  logic [63:0] cycle_cnt_q;
  logic [63:0] instr_cnt_q;

  logic run;
  logic acc;
  logic trap_hit;
  logic wdog_expire;

  logic unused_a0_hi;
  assign unused_a0_hi = ^a0_i[63:8];

  assign run      = (state_q == RUN);
  assign acc      = retire_i && run && !is_bubble(pc_i, inst_i);
  assign trap_hit = acc && (inst_i[6:0] == TRAP_OPCODE);

  commit_watchdog #(
    .WDOG_CYCLES(WDOG_CYCLES)
  ) u_wdog (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .run_i   (run),
    .clear_i (acc),
    .expire_o(wdog_expire)
  );

  always_comb begin
    state_d     = state_q;
    trap_code_d = trap_code_q;
    unique case (state_q)
      RUN: begin
        if (trap_hit) begin
          state_d     = HALT;
          trap_code_d = a0_i[7:0];
        end else if (wdog_expire) begin
          state_d     = HALT;
          trap_code_d = WDOG_CODE;
        end
      end
      HALT: state_d = HALT;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= RUN;
      trap_code_q <= 8'h0;
    end else begin
      state_q     <= state_d;
      trap_code_q <= trap_code_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cmt_valid_q <= 1'b0;
      cmt_pc_q    <= 64'h0;
      cmt_inst_q  <= 32'h0;
      cmt_skip_q  <= 1'b0;
      cmt_wen_q   <= 1'b0;
      cmt_rd_q    <= 5'h0;
      cmt_wdata_q <= 64'h0;
      cycle_cnt_q <= 64'h0;
      instr_cnt_q <= 64'h0;
    end else begin
      cmt_valid_q <= acc;
      if (acc) begin
        cmt_pc_q    <= pc_i;
        cmt_inst_q  <= inst_i;
        cmt_skip_q  <= skip_i;
        cmt_wen_q   <= rd_wen_i && (rd_i != 5'd0);
        cmt_rd_q    <= rd_i;
        cmt_wdata_q <= rd_wdata_i;
        instr_cnt_q <= instr_cnt_q + 64'd1;
      end
      if (run) cycle_cnt_q <= cycle_cnt_q + 64'd1;
    end
  end

`ifdef COMMIT_PUTCH_EN
  logic       uart_valid_q;
  logic [7:0] uart_ch_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      uart_valid_q <= 1'b0;
      uart_ch_q    <= 8'h0;
    end else begin
      uart_valid_q <= acc && (inst_i == PUTCH_INST);
      if (acc && (inst_i == PUTCH_INST)) uart_ch_q <= a0_i[7:0];
    end
  end

  assign uart_out_valid_o = uart_valid_q;
  assign uart_out_ch_o    = uart_ch_q;
`else
  assign uart_out_valid_o = 1'b0;
  assign uart_out_ch_o    = 8'h0;
`endif

  assign cmt_valid_o  = cmt_valid_q;
  assign cmt_pc_o     = cmt_pc_q;
  assign cmt_inst_o   = cmt_inst_q;
  assign cmt_skip_o   = cmt_skip_q;
  assign cmt_wen_o    = cmt_wen_q;
  assign cmt_wdest_o  = {3'b000, cmt_rd_q};
  assign cmt_wdata_o  = cmt_wdata_q;
  assign trap_valid_o = (state_q == HALT);
  assign trap_code_o  = trap_code_q;
  assign cycle_cnt_o  = cycle_cnt_q;
  assign instr_cnt_o  = instr_cnt_q;

endmodule

// File: tb/tb_commit_stage.sv
// Scoreboard bench for commit_stage (watchdog shortened to 16 cycles).
module tb_commit_stage;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        skip;
    logic        wen;
    logic [7:0]  wdest;
    logic [63:0] wdata;
  } cmt_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        retire_i = 1'b0;
  logic [63:0] pc_i = 64'h0;
  logic [31:0] inst_i = 32'h0;
  logic        rd_wen_i = 1'b0;
  logic [4:0]  rd_i = 5'h0;
  logic [63:0] rd_wdata_i = 64'h0;
  logic        skip_i = 1'b0;
  logic [63:0] a0_i = 64'h0;
  logic        cmt_valid_o;
  logic [63:0] cmt_pc_o;
  logic [31:0] cmt_inst_o;
  logic        cmt_skip_o;
  logic        cmt_wen_o;
  logic [7:0]  cmt_wdest_o;
  logic [63:0] cmt_wdata_o;
  logic        trap_valid_o;
  logic [7:0]  trap_code_o;
  logic [63:0] cycle_cnt_o;
  logic [63:0] instr_cnt_o;
  logic        uart_out_valid_o;
  logic [7:0]  uart_out_ch_o;

  int   passed = 0;
  int   total  = 0;
  cmt_t cq[$];
  logic [7:0] uq[$];

  commit_stage #(.WDOG_CYCLES(32'd16), .WDOG_CODE(8'hff)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .retire_i(retire_i), .pc_i(pc_i), .inst_i(inst_i),
    .rd_wen_i(rd_wen_i), .rd_i(rd_i), .rd_wdata_i(rd_wdata_i), .skip_i(skip_i), .a0_i(a0_i),
    .cmt_valid_o(cmt_valid_o), .cmt_pc_o(cmt_pc_o), .cmt_inst_o(cmt_inst_o),
    .cmt_skip_o(cmt_skip_o), .cmt_wen_o(cmt_wen_o), .cmt_wdest_o(cmt_wdest_o),
    .cmt_wdata_o(cmt_wdata_o), .trap_valid_o(trap_valid_o), .trap_code_o(trap_code_o),
    .cycle_cnt_o(cycle_cnt_o), .instr_cnt_o(instr_cnt_o),
    .uart_out_valid_o(uart_out_valid_o), .uart_out_ch_o(uart_out_ch_o)
  );

  always #5 clk_i = ~clk_i;

  // Scoreboard monitor: one entry expected per accepted retire, exactly one cycle later.
  always @(posedge clk_i) begin
    #1;
    total++;
    if (cq.size() > 0) begin
      cmt_t e;
      e = cq.pop_front();
      if (cmt_valid_o !== 1'b1 || cmt_pc_o !== e.pc || cmt_inst_o !== e.inst ||
          cmt_skip_o !== e.skip || cmt_wen_o !== e.wen || cmt_wdest_o !== e.wdest ||
          cmt_wdata_o !== e.wdata)
        $display("FAIL commit: got v=%b pc=%h inst=%h skip=%b wen=%b wdest=%h wdata=%h, want v=1 pc=%h inst=%h skip=%b wen=%b wdest=%h wdata=%h",
                 cmt_valid_o, cmt_pc_o, cmt_inst_o, cmt_skip_o, cmt_wen_o, cmt_wdest_o,
                 cmt_wdata_o, e.pc, e.inst, e.skip, e.wen, e.wdest, e.wdata);
      else passed++;
    end else begin
      if (cmt_valid_o !== 1'b0)
        $display("FAIL no_commit: cmt_valid got %b want 0 (t=%0t)", cmt_valid_o, $time);
      else passed++;
    end
    total++;
`ifdef COMMIT_PUTCH_EN
    if (uq.size() > 0) begin
      logic [7:0] ch;
      ch = uq.pop_front();
      if (uart_out_valid_o !== 1'b1 || uart_out_ch_o !== ch)
        $display("FAIL putch: got v=%b ch=%h want v=1 ch=%h", uart_out_valid_o, uart_out_ch_o, ch);
      else passed++;
    end else if (uart_out_valid_o !== 1'b0)
      $display("FAIL putch_idle: uart_out_valid got %b want 0", uart_out_valid_o);
    else passed++;
`else
    if (uart_out_valid_o !== 1'b0 || uart_out_ch_o !== 8'h0)
      $display("FAIL uart_tied: got v=%b ch=%h want 0/00", uart_out_valid_o, uart_out_ch_o);
    else passed++;
`endif
  end

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    retire_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk_i);
  endtask

  // Drive one retire for a single cycle; push the expected commit when it should be accepted.
  task automatic retire(input logic [63:0] pc, input logic [31:0] inst, input logic wen,
                        input logic [4:0] rd, input logic [63:0] wdata, input logic skip,
                        input logic [63:0] a0, input logic expect_acc);
    cmt_t e;
    retire_i = 1'b1; pc_i = pc; inst_i = inst; rd_wen_i = wen; rd_i = rd;
    rd_wdata_i = wdata; skip_i = skip; a0_i = a0;
    if (expect_acc) begin
      e.pc = pc; e.inst = inst; e.skip = skip; e.wen = wen && (rd != 5'd0);
      e.wdest = {3'b000, rd}; e.wdata = wdata;
      cq.push_back(e);
`ifdef COMMIT_PUTCH_EN
      if (inst == 32'h7) uq.push_back(a0[7:0]);
`endif
    end
    @(negedge clk_i);
    retire_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (cmt_valid_o !== 1'b0 || trap_valid_o !== 1'b0 || trap_code_o !== 8'h0 ||
        cycle_cnt_o !== 64'h0 || instr_cnt_o !== 64'h0 || cmt_pc_o !== 64'h0 || cmt_wen_o !== 1'b0)
      $display("FAIL reset: v=%b trap=%b code=%h cyc=%0d ins=%0d pc=%h wen=%b want all 0",
               cmt_valid_o, trap_valid_o, trap_code_o, cycle_cnt_o, instr_cnt_o, cmt_pc_o, cmt_wen_o);
    else passed++;
  endtask

  task automatic test_basic();
    do_reset();
    retire(64'h8000_0000, 32'h0010_0093, 1'b1, 5'd1, 64'd1, 1'b0, 64'h0, 1'b1);
    total++;
    if (instr_cnt_o !== 64'd1 || cycle_cnt_o !== 64'd1)
      $display("FAIL basic_cnt: instr=%0d cycle=%0d want 1/1", instr_cnt_o, cycle_cnt_o);
    else passed++;
  endtask

  task automatic test_bubble();
    do_reset();
    retire(64'h8000_0000, 32'h0, 1'b1, 5'd3, 64'h55, 1'b0, 64'h0, 1'b0);
    total++;
    if (instr_cnt_o !== 64'd0)
      $display("FAIL bubble_cnt: instr=%0d want 0", instr_cnt_o);
    else passed++;
    retire(64'h8000_0004, 32'h0000_0013, 1'b1, 5'd0, 64'hdead, 1'b1, 64'h0, 1'b1);
    // Data holds after the commit strobe drops.
    idle(1);
    total++;
    if (cmt_pc_o !== 64'h8000_0004 || cmt_wdata_o !== 64'hdead || cmt_skip_o !== 1'b1 || instr_cnt_o !== 64'd1)
      $display("FAIL hold: pc=%h wdata=%h skip=%b instr=%0d want 80000004/dead/1/1",
               cmt_pc_o, cmt_wdata_o, cmt_skip_o, instr_cnt_o);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [63:0] base;
    do_reset();
    base = instr_cnt_o;
    for (int i = 0; i < 10; i++) begin
      logic [31:0] w;
      w = $urandom;
      w[6:0] = 7'h33;
      retire(64'h8000_1000 + 64'(i * 4), w, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
             {32'($urandom), 32'($urandom)}, 1'($urandom_range(0, 1)), 64'h0, 1'b1);
    end
    total++;
    if (instr_cnt_o !== base + 64'd10 || cycle_cnt_o !== 64'd10)
      $display("FAIL b2b_cnt: instr=%0d cycle=%0d want %0d/10", instr_cnt_o, cycle_cnt_o, base + 64'd10);
    else passed++;
  endtask

  task automatic test_putch();
    do_reset();
    retire(64'h8000_0010, 32'h0000_0007, 1'b0, 5'd0, 64'h0, 1'b0, 64'h41, 1'b1);
    idle(2);
  endtask

  task automatic test_trap();
    logic [63:0] cyc;
    do_reset();
    retire(64'h8000_0000, 32'h0010_0093, 1'b1, 5'd1, 64'd1, 1'b0, 64'h0, 1'b1);
    retire(64'h8000_0004, 32'h0000_006b, 1'b0, 5'd0, 64'h0, 1'b0, 64'h0, 1'b1);
    total++;
    if (trap_valid_o !== 1'b1 || trap_code_o !== 8'h00 || instr_cnt_o !== 64'd2 || cycle_cnt_o !== 64'd2)
      $display("FAIL trap: trap=%b code=%h instr=%0d cycle=%0d want 1/00/2/2",
               trap_valid_o, trap_code_o, instr_cnt_o, cycle_cnt_o);
    else passed++;
    cyc = cycle_cnt_o;
    for (int i = 0; i < 4; i++)
      retire(64'h8000_0100 + 64'(i * 4), 32'h0000_0013, 1'b1, 5'd2, 64'h7, 1'b0, 64'h0, 1'b0);
    idle(20);
    total++;
    if (trap_valid_o !== 1'b1 || trap_code_o !== 8'h00 || instr_cnt_o !== 64'd2 || cycle_cnt_o !== cyc)
      $display("FAIL halt_frozen: trap=%b code=%h instr=%0d cycle=%0d want 1/00/2/%0d",
               trap_valid_o, trap_code_o, instr_cnt_o, cycle_cnt_o, cyc);
    else passed++;
  endtask

  task automatic test_rst_in_halt();
    do_reset();
    total++;
    if (trap_valid_o !== 1'b0 || cycle_cnt_o !== 64'd0 || instr_cnt_o !== 64'd0 || trap_code_o !== 8'h0)
      $display("FAIL rst_halt: trap=%b code=%h cycle=%0d instr=%0d want 0/00/0/0",
               trap_valid_o, trap_code_o, cycle_cnt_o, instr_cnt_o);
    else passed++;
    retire(64'h8000_0200, 32'h0020_0113, 1'b1, 5'd2, 64'h2, 1'b0, 64'h0, 1'b1);
    retire(64'h8000_0204, 32'h0000_006b, 1'b1, 5'd4, 64'h9, 1'b0, 64'h123, 1'b1);
    total++;
    if (trap_valid_o !== 1'b1 || trap_code_o !== 8'h23 || instr_cnt_o !== 64'd2)
      $display("FAIL bad_trap: trap=%b code=%h instr=%0d want 1/23/2", trap_valid_o, trap_code_o, instr_cnt_o);
    else passed++;
  endtask

  task automatic test_watchdog();
    do_reset();
    idle(15);
    total++;
    if (trap_valid_o !== 1'b0)
      $display("FAIL wdog_early: trap=%b want 0 after 15 idle cycles", trap_valid_o);
    else passed++;
    idle(1);
    total++;
    if (trap_valid_o !== 1'b1 || trap_code_o !== 8'hff || cycle_cnt_o !== 64'd16 || instr_cnt_o !== 64'd0)
      $display("FAIL wdog_fire: trap=%b code=%h cycle=%0d instr=%0d want 1/ff/16/0",
               trap_valid_o, trap_code_o, cycle_cnt_o, instr_cnt_o);
    else passed++;
    // Retire in the expiry cycle wins; the count restarts from there.
    do_reset();
    idle(15);
    retire(64'h8000_0300, 32'h0000_0013, 1'b0, 5'd0, 64'h0, 1'b0, 64'h0, 1'b1);
    total++;
    if (trap_valid_o !== 1'b0)
      $display("FAIL wdog_acc_wins: trap=%b want 0", trap_valid_o);
    else passed++;
    idle(15);
    total++;
    if (trap_valid_o !== 1'b0)
      $display("FAIL wdog_restart_early: trap=%b want 0", trap_valid_o);
    else passed++;
    idle(1);
    total++;
    if (trap_valid_o !== 1'b1 || trap_code_o !== 8'hff || cycle_cnt_o !== 64'd32)
      $display("FAIL wdog_restart: trap=%b code=%h cycle=%0d want 1/ff/32", trap_valid_o, trap_code_o, cycle_cnt_o);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bubble();
    test_back_to_back();
    test_putch();
    test_trap();
    test_rst_in_halt();
    test_watchdog();
    idle(2);
    total++;
    if (cq.size() != 0 || uq.size() != 0)
      $display("FAIL scoreboard_drain: %0d commits and %0d chars left", cq.size(), uq.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
